// File: rtl/memory_arbiter_if.sv
// Request-side, RAM-side and status signals of memory_arbiter.
// master: arbiter view; slave: pipeline/RAM environment view.
interface memory_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              mem_err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data ports; the data port has priority.
// Define MEM_ARB_FAIR_EN to cap consecutive data grants while an instruction fetch is waiting.
module memory_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    memory_arbiter_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              d_req_c;
    logic              ram_done_c;
    logic              i_done_c;
    logic              d_done_c;
    logic              fair_pick_c;
    logic              timeout_hit_c;
    logic              ram_ren_c;
    logic              ram_wen_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_store_c;
    logic [CNT_W-1:0]  to_cnt;
    logic              mem_err_q;

    if (MAX_DATA_STREAK == 0) begin : g_bad_streak
        $error("memory_arbiter: MAX_DATA_STREAK must be at least 1");
    end

    assign d_req_c    = bus.dREN | bus.dWEN;
    assign ram_done_c = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RAM strobes; strobes follow the live inputs of the granted port.
    always_comb begin
        state_nxt   = state;
        ram_ren_c   = 1'b0;
        ram_wen_c   = 1'b0;
        ram_addr_c  = '0;
        ram_store_c = '0;
        i_done_c    = 1'b0;
        d_done_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fair_pick_c) begin
                    state_nxt = GRANT_I;
                end else if (d_req_c) begin
                    state_nxt = GRANT_D;
                end else if (bus.iREN) begin
                    state_nxt = GRANT_I;
                end
            end
            GRANT_I: begin
                ram_ren_c  = 1'b1;
                ram_addr_c = bus.iaddr;
                if (!bus.iREN) begin
                    state_nxt = IDLE;
                end else if (ram_done_c) begin
                    i_done_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GRANT_D: begin
                ram_addr_c = bus.daddr;
                if (bus.dWEN) begin
                    ram_wen_c   = 1'b1;
                    ram_store_c = bus.dstore;
                end else begin
                    ram_ren_c = 1'b1;
                end
                if (!d_req_c) begin
                    state_nxt = IDLE;
                end else if (ram_done_c) begin
                    d_done_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fires on the grant cycle whose increment brings the counter to TIMEOUT_CYCLES.
    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                           (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (state_nxt == IDLE) begin
            to_cnt <= '0;
        end else if ((state != IDLE) && (to_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_err_q <= 1'b0;
        end else if (timeout_hit_c ||
                     ((i_done_c || d_done_c) && (bus.ramstate == RAM_ERROR))) begin
            mem_err_q <= 1'b1;
        end
    end

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    logic [STREAK_W-1:0] streak;

    // Counts data completions that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            streak <= '0;
        end else if (d_done_c) begin
            if (!bus.iREN) begin
                streak <= '0;
            end else if (streak != STREAK_W'(MAX_DATA_STREAK)) begin
                streak <= streak + STREAK_W'(1);
            end
        end else if (i_done_c) begin
            streak <= '0;
        end
    end

    assign fair_pick_c = bus.iREN && (streak == STREAK_W'(MAX_DATA_STREAK));
`else
    assign fair_pick_c = 1'b0;
`endif

    assign bus.iwait    = bus.iREN & ~i_done_c;
    assign bus.iload    = i_done_c ? bus.ramload : '0;
    assign bus.dwait    = d_req_c & ~d_done_c;
    assign bus.dload    = d_done_c ? bus.ramload : '0;
    assign bus.ramREN   = ram_ren_c;
    assign bus.ramWEN   = ram_wen_c;
    assign bus.ramaddr  = ram_addr_c;
    assign bus.ramstore = ram_store_c;
    assign bus.mem_err  = mem_err_q;
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port RAM between the instruction-fetch port (iREN) and the data-memory port (dREN/dWEN) driven by the pipeline's control signals.
- Registered FSM: latches one grant, holds RAM strobes until the RAM reports ACCESS, then returns wait/load to the granted requester.
- Sits between the pipelined datapath's memory interfaces and the RAM model.
- Data port has priority; optional fairness logic prevents instruction starvation.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYCLES, 64, cycles in a grant state before mem_err is raised; 0 disables the timeout.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while iREN is pending (used only with MEM_ARB_FAIR_EN).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  instruction stall; low only on the completing cycle.
- iload  out  DATA_W  instruction data; valid when iREN && !iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dwait  out  1  data stall.
- dload  out  DATA_W  read data; valid when dREN && !dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- mem_err  out  1  sticky error flag (RAM ERROR or timeout).

Behaviour:
- Reset, asynchronous: state IDLE; ramREN, ramWEN, ramaddr, ramstore = 0; mem_err = 0; timeout counter and streak counter = 0.
- Whenever reset is active, iwait = 1 if iREN is high and dwait = 1 if dREN|dWEN is high; iload and dload = 0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - If dREN|dWEN is high, go to GRANT_D.
  - Else if iREN is high, go to GRANT_I.
  - Else stay in IDLE.
  - No RAM strobes are driven in IDLE.
- GRANT_D: ramaddr = daddr. If dWEN is high: ramWEN = 1, ramREN = 0, ramstore = dstore. Otherwise ramREN = 1.
- GRANT_I: ramREN = 1, ramaddr = iaddr.
- RAM-side outputs are combinational from the state and the live request inputs.
- Completion occurs in a grant state when ramstate is ACCESS (2) or ERROR (3):
  - The granted requester's wait goes low on that cycle.
  - Its load output = ramload, passed combinationally.
  - Next state is IDLE.
- The non-granted requester's wait stays high on every cycle its request is asserted.
- ramstate ERROR completes the transaction and sets mem_err, sticky until reset.
- Abort: if the granted requester drops its request while in a grant state, go to IDLE next cycle; there is no completion and no error.
- Latency:
  - Request first seen in IDLE on cycle N, RAM strobes driven from cycle N+1.
  - With a zero-wait RAM (ACCESS on cycle N+1), wait goes low on cycle N+1.
  - Back-to-back accesses from one requester complete no faster than every 2 cycles.
- Timeout counter:
  - Increments every cycle spent in a grant state; clears on entry to IDLE.
  - Saturates at TIMEOUT_CYCLES. On reaching it, mem_err is set and the transaction continues.
- dREN and dWEN high together: treated as a write only.
- Address and data pass through unmodified; no width conversion.
- Outputs are held stable within a transaction only if the requester holds its inputs stable; the pipeline is required to do so while wait is high.

Optional Feature:
- Macro MEM_ARB_FAIR_EN.
- When defined:
  - A streak counter increments on each GRANT_D completion that occurs while iREN is high.
  - It clears on any GRANT_I completion, and whenever iREN is low at a GRANT_D completion.
  - When streak == MAX_DATA_STREAK and iREN is high, IDLE selects GRANT_I even if a data request is pending.
- When not defined: no streak counter; the data port always wins in IDLE.

Test Plan:
- Reset, then iREN=1, iaddr=0x0000_0004, RAM returns ACCESS on its first strobed cycle with ramload=0x2408_0001 -> ramREN=1 with ramaddr=0x4 on cycle 1; iwait=0 and iload=0x2408_0001 on cycle 1; state is IDLE on cycle 2.
- iREN=1 and dWEN=1 on the same cycle, daddr=0x80, dstore=0xDEAD_BEEF, RAM BUSY for 2 cycles then ACCESS -> ramWEN=1, ramstore=0xDEAD_BEEF, ramaddr=0x80; dwait low only on the ACCESS cycle; iwait held high throughout; GRANT_I follows.
- dREN=1 with ramstate stuck at BUSY, TIMEOUT_CYCLES=8 -> mem_err rises after 8 grant cycles; dwait stays high; mem_err remains set after ACCESS finally arrives; only RST clears it.
- GRANT_D in progress, RST pulsed high mid-wait -> ramREN/ramWEN drop to 0 asynchronously, before the next edge; state is IDLE after release; mem_err=0.
- With MEM_ARB_FAIR_EN, MAX_DATA_STREAK=4, dREN and iREN held continuously high, zero-wait RAM -> grant sequence D,D,D,D,I,D,D,D,D,I. Without the macro -> D every time and iwait never drops.
- dREN dropped while in GRANT_D -> IDLE next cycle, no dwait low pulse, mem_err=0; a pending iREN is then granted.
